// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter, LSB first.
// A one-word holding buffer sits in front of the shift register, so the next
// word can be accepted while the current one is still shifting. This lets
// frames follow each other with no idle cycle between them.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | shift register empty, bit_valid low
// SHIFT | shift register holds a word, bit_out = sreg[0]
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             frame_start,
  output logic             frame_last,
  output logic [15:0]      frame_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hbuf;
  logic             hvalid;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  logic accept;
  logic bit_hs;
  logic at_last;
  logic load;

  assign accept  = in_valid && in_ready;
  assign bit_hs  = bit_valid && bit_ready;
  assign at_last = (cnt == CNT_LAST);
  // The shifter reloads either from empty or directly on the final bit
  // handshake. A reload always wins over an accept, because hvalid=1 already
  // holds in_ready low.
  assign load    = hvalid && ((state == IDLE) || (bit_hs && at_last));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: leave SHIFT only when the last bit goes and nothing is waiting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hvalid) state_nxt = SHIFT;
      SHIFT:   if (bit_hs && at_last && !hvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs, all decoded from registers; in_ready is held low during reset
  always_comb begin
    in_ready    = rst_n && !hvalid;
    bit_valid   = (state == SHIFT);
    bit_out     = bit_valid && sreg[0];
    frame_start = bit_valid && (cnt == '0);
    frame_last  = bit_valid && at_last;
  end

  // Datapath: holding buffer, shift register, bit counter, frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hbuf        <= '0;
      hvalid      <= 1'b0;
      sreg        <= '0;
      cnt         <= '0;
      frame_count <= '0;
    end else begin
      if (load) begin
        sreg   <= hbuf;
        cnt    <= '0;
        hvalid <= 1'b0;
      end else if (bit_hs) begin
        if (at_last) begin
          cnt <= '0;
        end else begin
          sreg <= sreg >> 1;
          cnt  <= cnt + CW'(1);
        end
      end
      if (accept) begin
        hbuf   <= in_data;
        hvalid <= 1'b1;
      end
      if (bit_hs && at_last) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  holding buffer empty, word accepted on in_valid && in_ready.
REQ-007 SHALL have port bit_out  output  1  current serial bit, LSB first.
REQ-008 SHALL have port bit_valid  output  1  bit_out valid.
REQ-009 SHALL have port bit_ready  input  1  downstream consumes bit on bit_valid && bit_ready.
REQ-010 SHALL have port frame_start  output  1  high while bit_out is bit 0 of a word; downstream restarts its per-word FSM on it.
REQ-011 SHALL have port frame_last  output  1  high while bit_out is bit WIDTH-1.
REQ-012 SHALL have port frame_count  output  16  words fully transmitted.

Function
REQ-013 SHALL hold one holding buffer (hbuf, hvalid), one shift register (sreg), and a bit counter cnt of width clog2(WIDTH).
REQ-014 SHALL use states IDLE (shifter empty) and SHIFT (shifter holds a word).
REQ-015 SHALL drive in_ready = !hvalid, forced 0 while rst_n low.
REQ-016 SHALL write in_data into hbuf and set hvalid on an accept edge.
REQ-017 SHALL, in IDLE with hvalid=1, load sreg<=hbuf, cnt<=0, clear hvalid, and go to SHIFT.
REQ-018 SHALL drive bit_valid=1 exactly in SHIFT, with bit_out=sreg[0].
REQ-019 SHALL, on a bit handshake with cnt<WIDTH-1, shift sreg right by one and increment cnt.
REQ-020 SHALL, on a bit handshake with cnt=WIDTH-1, increment frame_count and then do one of two things: if hvalid=1, load hbuf and stay in SHIFT with no idle cycle; otherwise go to IDLE.
REQ-021 SHALL wrap frame_count from 0xFFFF to 0x0000.
REQ-022 SHALL hold bit_out, bit_valid, frame_start, frame_last and cnt unchanged while bit_valid=1 and bit_ready=0.
REQ-023 SHALL derive frame_start = bit_valid && cnt==0 and frame_last = bit_valid && cnt==WIDTH-1, combinationally from registers.
REQ-024 SHALL, when a load from hbuf and a new accept fall on the same edge, give priority to the load; in_ready is 0 at that edge, so no accept occurs.
REQ-025 SHALL, after a word is accepted at edge N into an empty block, present bit 0 in the cycle after edge N+1 (load latency 2 edges).
REQ-026 SHALL ignore bit_ready while bit_valid=0.
REQ-027 SHALL ignore in_data while no accept occurs.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: state=IDLE, hvalid=0, sreg=0, cnt=0, frame_count=0, bit_valid=0, bit_out=0, frame_start=0, frame_last=0, in_ready=0.
REQ-029 SHALL discard any word partially shifted or held when reset is asserted mid-frame, and SHALL NOT emit a partial frame after release.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-031 SHALL be verified with a single word: WIDTH=8, bit_ready=1, accept 0xB4 -> bit_out sequence 0,0,1,0,1,1,0,1 on 8 consecutive cycles; frame_start on the first bit, frame_last on the eighth; frame_count=1.
REQ-032 SHALL be verified back-to-back: accept 0x01 then 0x80 while the first word is shifting -> 16 contiguous bit_valid cycles with no gap; frame_start at bits 0 and 8; frame_count=2.
REQ-033 SHALL be verified under backpressure: bit_ready=0 for 3 cycles at bit 3 of 0xF0 -> bit_out, cnt and frame_last stable for those 3 cycles; the full sequence is still correct.
REQ-034 SHALL be verified full: with the shifter busy and hbuf loaded -> in_ready=0; in_valid held with new data is not accepted until the last-bit handshake reloads the shifter.
REQ-035 SHALL be verified for reset mid-frame: assert rst_n=0 at bit 5 -> all outputs 0 immediately (asynchronously); after release, bit_valid=0 until a new word is accepted; frame_count=0.
REQ-036 SHALL be verified for wrap: preload by running 65536 frames (or force) -> frame_count goes 0xFFFF to 0x0000 on the final last-bit handshake.
